// File: rtl/gbf_arb_pkg.sv
// Shared constants and width helpers for the flag/activation global-buffer arbiter.
package gbf_arb_pkg;

    localparam int DEF_NUM_RD     = 4;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_DATA_W     = 28;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STALL_CNT_W    = 16;

    function automatic int id_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    // The streak counter must reach STARVE_MAX and is never narrower than 3 bits.
    function automatic int streak_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/gbf_rr_pick.sv
// Combinational round-robin selector: first requester at or above ptr, wrapping modulo NUM_RD.
module gbf_rr_pick #(
    parameter int NUM_RD = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_RD-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic [NUM_RD-1:0] gnt,
    output logic [ID_W-1:0]   id,
    output logic              found
);

    logic [ID_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            cand = ID_W'((int'(ptr) + k) % NUM_RD);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                id        = cand;
            end
        end
    end

endmodule

// File: rtl/gbf_flgact_arbiter.sv
// Single-port flag/activation buffer arbiter: one fill writer, NUM_RD round-robin readers.
// Optional write-streak starvation guard enabled by defining GBF_ARB_STARVE_GUARD_EN.
module gbf_flgact_arbiter
    import gbf_arb_pkg::*;
#(
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    parameter int ID_W       = id_width(NUM_RD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_gnt,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic                     rd_dat_vld,
    output logic [ID_W-1:0]          rd_dat_id,
    output logic [DATA_W-1:0]        rd_dat,
    output logic                     ram_read_en,
    output logic                     ram_write_en,
    output logic [ADDR_W-1:0]        ram_addr_r,
    output logic [ADDR_W-1:0]        ram_addr_w,
    output logic [DATA_W-1:0]        ram_data_in,
    input  logic [DATA_W-1:0]        ram_data_out,
    output logic [STALL_CNT_W-1:0]   stall_cnt
);

    if (NUM_RD < 2 || NUM_RD > 8 || STARVE_MAX < 1) begin : g_bad_params
        $error("gbf_flgact_arbiter: NUM_RD must be 2..8 and STARVE_MAX >= 1");
    end

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   next_ptr;
    logic [NUM_RD-1:0] pick_gnt;
    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic              rd_pending;
    logic              force_read;
    logic              rd_grant;
    logic              stalled;

    gbf_rr_pick #(
        .NUM_RD(NUM_RD),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req  (rd_req),
        .ptr  (rr_ptr),
        .gnt  (pick_gnt),
        .id   (pick_id),
        .found(pick_found)
    );

    assign rd_pending = |rd_req;

`ifdef GBF_ARB_STARVE_GUARD_EN
    localparam int STREAK_W = streak_width(STARVE_MAX);

    logic [STREAK_W-1:0] wr_streak;

    assign force_read = rd_pending && (wr_streak == STREAK_W'(STARVE_MAX));

    // Consecutive writes that kept a pending read waiting; any read grant or idle read side clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_streak <= '0;
        end else if (!rd_pending || rd_grant) begin
            wr_streak <= '0;
        end else if (wr_gnt) begin
            wr_streak <= wr_streak + 1'b1;
        end
    end
`else
    assign force_read = 1'b0;
`endif

    // One access per cycle; grants are held low for the whole reset assertion.
    always_comb begin
        wr_gnt   = 1'b0;
        rd_gnt   = '0;
        rd_grant = 1'b0;
        if (rst_n) begin
            if (wr_req && !force_read) begin
                wr_gnt = 1'b1;
            end else if (pick_found) begin
                rd_gnt   = pick_gnt;
                rd_grant = 1'b1;
            end
        end
    end

    always_comb begin
        ram_addr_r = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_gnt[i]) begin
                ram_addr_r = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ram_read_en  = rd_grant;
    assign ram_write_en = wr_gnt;
    assign ram_addr_w   = wr_addr;
    assign ram_data_in  = wr_data;
    assign rd_dat       = ram_data_out;

    assign stalled  = (wr_req & ~wr_gnt) | (|(rd_req & ~rd_gnt));
    assign next_ptr = (pick_id == ID_W'(NUM_RD - 1)) ? '0 : pick_id + 1'b1;

    // Return tag follows the grant by one cycle, matching the wrapper's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            rd_dat_vld <= 1'b0;
            rd_dat_id  <= '0;
            stall_cnt  <= '0;
        end else begin
            rd_dat_vld <= rd_grant;
            if (rd_grant) begin
                rd_dat_id <= pick_id;
                rr_ptr    <= next_ptr;
            end
            if (stalled && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    a_exclusive_access: assert property (@(posedge clk) disable iff (!rst_n)
        !(ram_read_en && ram_write_en));

endmodule

// File: tb/tb_gbf_flgact_arbiter.sv
// Self-checking bench for gbf_flgact_arbiter: table vectors, directed corner sequences and
// randomized traffic against a cycle-level reference model. Honours GBF_ARB_STARVE_GUARD_EN.
module tb_gbf_flgact_arbiter;

    localparam int NUM_RD     = 4;
    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 28;
    localparam int STARVE_MAX = 4;
    localparam int ID_W       = 2;
`ifdef GBF_ARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic                     wr_req;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     wr_gnt;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_gnt;
    logic                     rd_dat_vld;
    logic [ID_W-1:0]          rd_dat_id;
    logic [DATA_W-1:0]        rd_dat;
    logic                     ram_read_en;
    logic                     ram_write_en;
    logic [ADDR_W-1:0]        ram_addr_r;
    logic [ADDR_W-1:0]        ram_addr_w;
    logic [DATA_W-1:0]        ram_data_in;
    logic [DATA_W-1:0]        ram_data_out;
    logic [15:0]              stall_cnt;

    gbf_flgact_arbiter #(
        .NUM_RD    (NUM_RD),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_gnt      (rd_gnt),
        .rd_dat_vld  (rd_dat_vld),
        .rd_dat_id   (rd_dat_id),
        .rd_dat      (rd_dat),
        .ram_read_en (ram_read_en),
        .ram_write_en(ram_write_en),
        .ram_addr_r  (ram_addr_r),
        .ram_addr_w  (ram_addr_w),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM wrapper with one-cycle registered read.
    logic [DATA_W-1:0] ram_mem [1<<ADDR_W];
    always @(posedge clk) begin
        if (ram_write_en) ram_mem[ram_addr_w] <= ram_data_in;
        if (ram_read_en)  ram_data_out <= ram_mem[ram_addr_r];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int                m_ptr = 0;
    int                m_stall = 0;
    int                m_streak = 0;
    bit                m_vld = 1'b0;
    int                m_id = 0;
    logic [DATA_W-1:0] m_dat = '0;
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];
    bit                model_wr;
    int                model_id;

    logic              last_wr_gnt;
    logic [NUM_RD-1:0] last_rd_gnt;
    logic              last_re;

    typedef struct {
        logic              wr;
        logic [NUM_RD-1:0] rq;
        logic              exp_wr;
        logic [NUM_RD-1:0] exp_rd;
    } vec_t;
    vec_t tbl [9];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic applyStimulus(input logic rst_v, input logic wr_v, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic [NUM_RD-1:0] rq,
                                 input logic [NUM_RD*ADDR_W-1:0] ra);
        bit                exp_wr;
        int                exp_id;
        logic [NUM_RD-1:0] exp_gnt;
        logic [ADDR_W-1:0] exp_ar;
        bit                force_rd;
        bit                stalled;
        int                c;
        @(negedge clk);
        rst_n   = rst_v;
        wr_req  = wr_v;
        wr_addr = wa;
        wr_data = wd;
        rd_req  = rq;
        rd_addr = ra;
        if (!rst_v) begin
            m_ptr = 0; m_stall = 0; m_streak = 0; m_vld = 1'b0; m_id = 0;
        end
        #1;
        exp_wr = 1'b0; exp_id = -1; exp_gnt = '0; exp_ar = '0;
        if (rst_v) begin
            force_rd = GUARD_ON && (m_streak == STARVE_MAX) && (rq != 0);
            if (wr_v && !force_rd) exp_wr = 1'b1;
            else begin
                for (int k = 0; k < NUM_RD; k++) begin
                    c = (m_ptr + k) % NUM_RD;
                    if (exp_id < 0 && rq[c]) exp_id = c;
                end
            end
        end
        if (exp_id >= 0) begin
            exp_gnt[exp_id] = 1'b1;
            exp_ar = ra[exp_id*ADDR_W +: ADDR_W];
        end
        checkOutput("wr_gnt", 32'(wr_gnt), 32'(exp_wr));
        checkOutput("rd_gnt", 32'(rd_gnt), 32'(exp_gnt));
        checkOutput("ram_write_en", 32'(ram_write_en), 32'(exp_wr));
        checkOutput("ram_read_en", 32'(ram_read_en), 32'(exp_id >= 0));
        checkOutput("ram_addr_r", 32'(ram_addr_r), 32'(exp_ar));
        checkOutput("ram_addr_w", 32'(ram_addr_w), 32'(wa));
        checkOutput("ram_data_in", 32'(ram_data_in), 32'(wd));
        checkOutput("rd_dat_vld", 32'(rd_dat_vld), 32'(m_vld));
        if (m_vld) begin
            checkOutput("rd_dat_id", 32'(rd_dat_id), 32'(m_id));
            checkOutput("rd_dat", 32'(rd_dat), 32'(m_dat));
        end
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        last_wr_gnt = wr_gnt;
        last_rd_gnt = rd_gnt;
        last_re     = ram_read_en;
        @(posedge clk);
        if (rst_v) begin
            stalled = (wr_v && !exp_wr) || ((rq & ~exp_gnt) != 0);
            if (stalled && m_stall < 65535) m_stall++;
            if (rq == 0 || exp_id >= 0) m_streak = 0;
            else if (exp_wr) m_streak++;
            m_vld = (exp_id >= 0);
            if (exp_id >= 0) begin
                m_id  = exp_id;
                m_dat = ref_mem[exp_ar];
                m_ptr = (exp_id + 1) % NUM_RD;
            end
            if (exp_wr) ref_mem[wa] = wd;
        end
        model_wr = exp_wr;
        model_id = exp_id;
        #1;
    endtask

    initial begin
        #1_500_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        logic [NUM_RD*ADDR_W-1:0] ra_fixed;
        logic [NUM_RD*ADDR_W-1:0] ra_var;
        logic [NUM_RD-1:0]        pend;
        bit                       wpend;
        logic [ADDR_W-1:0]        waddr;
        logic [DATA_W-1:0]        wdata;
        logic                     rst_v;
        int                       rd_cnt;
        int                       wr_cnt;
        bit                       exp_r;

        tbl[0] = '{1'b0, 4'b0000, 1'b0, 4'b0000};
        tbl[1] = '{1'b0, 4'b0100, 1'b0, 4'b0100};
        tbl[2] = '{1'b0, 4'b0011, 1'b0, 4'b0001};
        tbl[3] = '{1'b1, 4'b0011, 1'b1, 4'b0000};
        tbl[4] = '{1'b0, 4'b0011, 1'b0, 4'b0010};
        tbl[5] = '{1'b0, 4'b1001, 1'b0, 4'b1000};
        tbl[6] = '{1'b0, 4'b1111, 1'b0, 4'b0001};
        tbl[7] = '{1'b1, 4'b0000, 1'b1, 4'b0000};
        tbl[8] = '{1'b0, 4'b1101, 1'b0, 4'b0100};

        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = '0; rd_addr = '0;
        ra_fixed = {6'd11, 6'd10, 6'd9, 6'd8};

        $display("[TB] reset");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        applyStimulus(1'b0, 1'b1, '0, '0, 4'b1111, ra_fixed);
        checkOutput("reset_wr_gnt", 32'(last_wr_gnt), 32'd0);
        checkOutput("reset_rd_gnt", 32'(last_rd_gnt), 32'd0);
        checkOutput("reset_vld", 32'(rd_dat_vld), 32'd0);
        checkOutput("reset_id", 32'(rd_dat_id), 32'd0);
        checkOutput("reset_stall", 32'(stall_cnt), 32'd0);

        $display("[TB] prefill memory through the writer port");
        for (int a = 0; a < (1 << ADDR_W); a++) begin
            applyStimulus(1'b1, 1'b1, ADDR_W'(a), (a == 5) ? 28'h0ABCDEF : DATA_W'($urandom), '0, ra_fixed);
        end

        $display("[TB] table vectors");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, tbl[i].wr, 6'd3, 28'h1234567, tbl[i].rq, ra_fixed);
            checkOutput($sformatf("tbl%0d_wr_gnt", i), 32'(last_wr_gnt), 32'(tbl[i].exp_wr));
            checkOutput($sformatf("tbl%0d_rd_gnt", i), 32'(last_rd_gnt), 32'(tbl[i].exp_rd));
            checkOutput($sformatf("tbl%0d_read_en", i), 32'(last_re), 32'(tbl[i].exp_rd != 0));
        end

        $display("[TB] single read and write conflict");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        ra_var = {6'd0, 6'd5, 6'd7, 6'd0};
        applyStimulus(1'b1, 1'b0, '0, '0, 4'b0100, ra_var);
        checkOutput("single_rd_gnt", 32'(last_rd_gnt), 32'b0100);
        checkOutput("single_vld", 32'(rd_dat_vld), 32'd1);
        checkOutput("single_id", 32'(rd_dat_id), 32'd2);
        checkOutput("single_dat", 32'(rd_dat), 32'h0ABCDEF);
        applyStimulus(1'b1, 1'b1, 6'd7, 28'h5555555, 4'b0001, ra_var);
        checkOutput("conflict_wr_gnt", 32'(last_wr_gnt), 32'd1);
        checkOutput("conflict_rd_gnt", 32'(last_rd_gnt), 32'd0);
        checkOutput("conflict_stall", 32'(stall_cnt), 32'd1);
        applyStimulus(1'b1, 1'b0, '0, '0, 4'b0001, ra_var);
        checkOutput("conflict_next_rd_gnt", 32'(last_rd_gnt), 32'b0001);
        checkOutput("conflict_next_id", 32'(rd_dat_id), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 4'b0010, ra_var);
        checkOutput("raw_dat", 32'(rd_dat), 32'h5555555);

        $display("[TB] round-robin");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, '0, '0, 4'b1111, ra_fixed);
            checkOutput("rr_gnt", 32'(last_rd_gnt), 32'(1 << (i % 4)));
            checkOutput("rr_vld", 32'(rd_dat_vld), 32'd1);
            checkOutput("rr_id", 32'(rd_dat_id), 32'(i % 4));
        end

        $display("[TB] starvation sequence");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        rd_cnt = 0; wr_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 6'd20, 28'h0F0F0F0, 4'b0010, ra_fixed);
            exp_r = GUARD_ON && (i % 5 == 4);
            checkOutput("starve_rd_gnt", 32'(last_rd_gnt), exp_r ? 32'b0010 : 32'd0);
            rd_cnt += int'(last_rd_gnt[1]);
            wr_cnt += int'(last_wr_gnt);
        end
        checkOutput("starve_rd_total", 32'(rd_cnt), GUARD_ON ? 32'd2 : 32'd0);
        checkOutput("starve_wr_total", 32'(wr_cnt), GUARD_ON ? 32'd8 : 32'd10);

        $display("[TB] reset during read return");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        applyStimulus(1'b1, 1'b0, '0, '0, 4'b0010, ra_fixed);
        applyStimulus(1'b0, 1'b1, '0, '0, 4'b1111, ra_fixed);
        checkOutput("midrst_wr_gnt", 32'(last_wr_gnt), 32'd0);
        checkOutput("midrst_rd_gnt", 32'(last_rd_gnt), 32'd0);
        checkOutput("midrst_vld", 32'(rd_dat_vld), 32'd0);
        checkOutput("midrst_stall", 32'(stall_cnt), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, ra_fixed);
        checkOutput("midrst_vld_after", 32'(rd_dat_vld), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, '0, 4'b1111, ra_fixed);
        checkOutput("midrst_ptr_cleared", 32'(last_rd_gnt), 32'b0001);

        $display("[TB] randomized traffic");
        pend = '0; wpend = 1'b0; waddr = '0; wdata = '0; ra_var = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!wpend && $urandom_range(0, 2) == 0) begin
                wpend = 1'b1;
                waddr = ADDR_W'($urandom);
                wdata = DATA_W'($urandom);
            end
            for (int i = 0; i < NUM_RD; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ra_var[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
                end
            end
            rst_v = ($urandom_range(0, 199) != 0);
            applyStimulus(rst_v, wpend, waddr, wdata, pend, ra_var);
            if (!rst_v) begin
                wpend = 1'b0;
                pend  = '0;
            end else begin
                if (model_wr) wpend = 1'b0;
                if (model_id >= 0) pend[model_id] = 1'b0;
            end
        end

        $display("[TB] stall counter saturation");
        applyStimulus(1'b0, 1'b0, '0, '0, '0, ra_fixed);
        for (int n = 0; n < 65600; n++) begin
            applyStimulus(1'b1, 1'b1, 6'd1, 28'h0000001, 4'b0011, ra_fixed);
        end
        checkOutput("stall_saturated", 32'(stall_cnt), 32'hFFFF);
        applyStimulus(1'b1, 1'b1, 6'd1, 28'h0000001, 4'b0011, ra_fixed);
        checkOutput("stall_holds", 32'(stall_cnt), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
